seg_hex_scan: RTL and testbench
===============================

// Module: seg_hex_scan
// PURPOSE
//   Time-multiplexed 8-digit hex display driver downstream of the ALU datapath.
//   Takes a 32-bit result word and scans it onto one 8-bit segment bus plus a 3-bit digit select (which).
//   Data is double-buffered so a new word is shown only from a frame start; no mixed old/new digits (no tearing).
// PARAMETERS
//   SCAN_DIV      100000  clk cycles per digit slot (>=2); 100 MHz -> 1 kHz digit rate
//   SEG_ACT_LOW   0       1: seg bits active-low (on=0); 0: active-high
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   data        in   32  word to display; nibble i -> digit i (digit 0 = rightmost)
//   load        in   1   1-cycle strobe: capture data into pending buffer
//   dp_mask     in   8   bit i lights decimal point of digit i (sampled live)
//   seg         out  8   segments {dp,g,f,e,d,c,b,a}; seg[0]=a, seg[7]=dp
//   which       out  3   index of digit currently driven
//   frame_done  out  1   1-cycle pulse when scan wraps from digit 7 to digit 0
// BEHAVIOUR
//   Reset (async, rst_n=0): prescaler=0, which=0, pending=0, display=0, frame_done=0,
//     seg=blank (8'h00 if SEG_ACT_LOW=0, 8'hFF if 1). Release takes effect next clk edge.
//   Prescaler: counts 0..SCAN_DIV-1; tick asserted in cycle where count==SCAN_DIV-1, count->0.
//   On tick: which <= which+1 (mod 8; 7 wraps to 0). which and seg update on same edge, always aligned.
//   seg (registered): pattern for nibble display[4*w+3:4*w] at w = new which, plus dp_mask[w] on seg[7];
//     polarity inverted as a whole when SEG_ACT_LOW=1. Recomputed every cycle from current which.
//   Hex patterns (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//     A=77 b=7C C=39 d=5E E=79 F=71.
//   Buffering: load=1 -> pending <= data. Frame boundary = tick with which==7:
//     display <= (load ? data : pending); frame_done=1 for that one cycle.
//   Simultaneous load + frame boundary: new data goes to both pending and display (bypass).
//   Multiple loads within one frame: last one wins; earlier ones never shown.
//   Mid-frame load: digits for remainder of current frame still come from old display.
//   Reset mid-scan: aborts scan; next frame starts at which=0 with display=0 (shows 00000000).
//   No other handshake; load is never back-pressured.
// CONFIGURATION
//   Macro SEG_BLANK_LEADING_ZERO_EN:
//     defined: digits above the highest non-zero nibble of display are blanked (segments a-g off);
//       digit 0 always shown; dp still driven from dp_mask on blanked digits.
//     undefined: all 8 digits always shown, leading zeros displayed as '0'.
// STRUCTURE
//   Shared package seg_defs: 16-entry hex segment pattern constants, SEG_BLANK (8'h00),
//     bit-position constants for a..g/dp, digit count (8) and index width (3).
//   Sub-module hex_to_seg7: combinational 4-bit nibble -> 7-bit pattern using seg_defs constants.
//   Top holds prescaler, digit counter, pending/display registers, blanking logic, output regs.
// TESTING  (bench uses SCAN_DIV=4, SEG_ACT_LOW=0 unless noted)
//   1 rst_n low mid-scan at which=5 -> same instant which=0, seg=8'h00, frame_done=0; after release
//     first frame shows 3F on all digits.
//   2 load 32'h1234ABCD, wait frame_done -> next frame: which=0 seg=5E, 1 seg=39, 3 seg=77,
//     7 seg=06; each digit held exactly 4 cycles; frame_done period 32 cycles.
//   3 load 32'hFFFF0000 at which=3 mid-frame -> digits 4..7 of that frame still old value;
//     F pattern (71) appears only after frame_done.
//   4 load asserted in the exact frame-boundary cycle with 32'h00000009 -> next which=0 shows 6F.
//   5 dp_mask=8'h04, data 0 -> seg=BF when which==2, seg=3F otherwise; SEG_ACT_LOW=1 -> 40 / C0.
//   6 with SEG_BLANK_LEADING_ZERO_EN, data 32'h000000A0 -> digits 7..2 seg=00, digit 1=77,
//     digit 0=3F; data 0 -> only digit 0 lit (3F).

Source files
------------

// File: rtl/seg_hex_scan_pkg.sv
// rtl/seg_hex_scan_pkg.sv - seg_defs package: hex segment patterns, segment bit positions, digit geometry
package seg_defs;

    localparam int DIGITS = 8;
    localparam int IDX_W  = 3;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high gfedcba patterns; concatenation lists entry 15 first.
    localparam logic [15:0][6:0] HEX_PAT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_hex_scan_hex_to_seg7.sv
// rtl/seg_hex_scan_hex_to_seg7.sv - combinational nibble to 7-segment (gfedcba) pattern
module hex_to_seg7
    import seg_defs::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_PAT[nibble];

endmodule

// File: rtl/seg_hex_scan.sv
// rtl/seg_hex_scan.sv - double-buffered 8-digit hex scan driver; SEG_BLANK_LEADING_ZERO_EN blanks leading zeros
module seg_hex_scan
    import seg_defs::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      data,
    input  logic             load,
    input  logic [7:0]       dp_mask,
    output logic [7:0]       seg,
    output logic [IDX_W-1:0] which,
    output logic             frame_done
);

    localparam int         CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [7:0] SEG_RST = SEG_ACT_LOW ? ~SEG_BLANK : SEG_BLANK;

    logic [CNT_W-1:0] cnt;
    logic [31:0]      pending;
    logic [31:0]      display;

    logic             tick;
    logic             frame_edge;
    logic [IDX_W-1:0] which_next;
    logic [31:0]      display_next;
    logic [3:0]       nibble;
    logic [6:0]       pattern;
    logic             lit;
    logic [7:0]       seg_hi;

    assign tick         = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_edge   = tick && (which == IDX_W'(DIGITS - 1));
    assign which_next   = tick ? which + IDX_W'(1) : which;
    // A load landing on the frame boundary bypasses pending straight into display.
    assign display_next = frame_edge ? (load ? data : pending) : display;
    assign nibble       = display_next[{which_next, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble  (nibble),
        .pattern (pattern)
    );

`ifdef SEG_BLANK_LEADING_ZERO_EN
    logic [IDX_W-1:0] top_digit;

    always_comb begin
        top_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (display_next[4*i +: 4] != 4'h0) begin
                top_digit = IDX_W'(i);
            end
        end
    end

    assign lit = (which_next <= top_digit);
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        seg_hi                = SEG_BLANK;
        seg_hi[SEG_G:SEG_A]   = lit ? pattern : 7'h00;
        seg_hi[SEG_DP]        = dp_mask[which_next];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            which      <= '0;
            pending    <= '0;
            display    <= '0;
            frame_done <= 1'b0;
            seg        <= SEG_RST;
        end else begin
            cnt        <= tick ? '0 : cnt + CNT_W'(1);
            which      <= which_next;
            display    <= display_next;
            frame_done <= frame_edge;
            seg        <= SEG_ACT_LOW ? ~seg_hi : seg_hi;
            if (load) begin
                pending <= data;
            end
        end
    end

endmodule

// File: tb/tb_seg_hex_scan.sv
// tb/tb_seg_hex_scan.sv - directed self-checking bench for seg_hex_scan (SCAN_DIV=4)
module tb_seg_hex_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data = '0;
    logic        load = 1'b0;
    logic [7:0]  dp_mask = '0;

    logic [7:0]  seg, seg_n;
    logic [2:0]  which, which_n;
    logic        frame_done, frame_done_n;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SEG_BLANK_LEADING_ZERO_EN
    localparam logic [7:0] LZ = 8'h00;
`else
    localparam logic [7:0] LZ = 8'h3F;
`endif

    logic [7:0] tab_1234 [8] = '{8'h5E, 8'h39, 8'h7C, 8'h77, 8'h66, 8'h4F, 8'h5B, 8'h06};

    always #5 clk = ~clk;

    seg_hex_scan #(.SCAN_DIV(4), .SEG_ACT_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .load(load), .dp_mask(dp_mask),
        .seg(seg), .which(which), .frame_done(frame_done)
    );

    seg_hex_scan #(.SCAN_DIV(4), .SEG_ACT_LOW(1'b1)) dut_n (
        .clk(clk), .rst_n(rst_n), .data(data), .load(load), .dp_mask(dp_mask),
        .seg(seg_n), .which(which_n), .frame_done(frame_done_n)
    );

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL wait_frame: frame_done=0 after 100 cycles, required 1");
        end
    endtask

    task automatic wait_which(input logic [2:0] w);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (which == w);
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL wait_which: which=%0d after 100 cycles, required %0d", which, w);
        end
    endtask

    task automatic pulse_load(input logic [31:0] d);
        data = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] ew;
        repeat (2) @(negedge clk);
        n_checks++; if (seg !== 8'h00) begin n_fail++; $display("FAIL reset_seg: got %h required 00", seg); end
        n_checks++; if (seg_n !== 8'hFF) begin n_fail++; $display("FAIL reset_seg_n: got %h required ff", seg_n); end
        n_checks++; if (which !== 3'd0) begin n_fail++; $display("FAIL reset_which: got %0d required 0", which); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (seg !== 8'h3F) begin n_fail++; $display("FAIL release_seg: got %h required 3f", seg); end

        pulse_load(32'h1234ABCD);
        wait_frame();
        wait_which(3'd5);
        rst_n = 1'b0;
        #1;
        n_checks++; if (which !== 3'd0) begin n_fail++; $display("FAIL midreset_which: got %0d required 0", which); end
        n_checks++; if (seg !== 8'h00) begin n_fail++; $display("FAIL midreset_seg: got %h required 00", seg); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midreset_frame_done: got %b required 0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ew = 3'((i + 1) / 4);
            n_checks++; if (which !== ew) begin n_fail++; $display("FAIL postreset_which[%0d]: got %0d required %0d", i, which, ew); end
            n_checks++; if (seg !== ((ew == 3'd0) ? 8'h3F : LZ)) begin n_fail++; $display("FAIL postreset_seg[%0d]: got %h", i, seg); end
            n_checks++; if (frame_done !== (i == 31)) begin n_fail++; $display("FAIL postreset_frame_done[%0d]: got %b required %b", i, frame_done, i == 31); end
        end
    endtask

    task automatic test_frame();
        logic [2:0] ew;
        pulse_load(32'h1234ABCD);
        wait_frame();
        for (int i = 0; i <= 32; i++) begin
            ew = 3'((i / 4) % 8);
            n_checks++; if (which !== ew) begin n_fail++; $display("FAIL frame_which[%0d]: got %0d required %0d", i, which, ew); end
            n_checks++; if (seg !== tab_1234[ew]) begin n_fail++; $display("FAIL frame_seg[%0d]: got %h required %h", i, seg, tab_1234[ew]); end
            n_checks++; if (frame_done !== (i == 0 || i == 32)) begin n_fail++; $display("FAIL frame_done_period[%0d]: got %b", i, frame_done); end
            if (i < 32) @(negedge clk);
        end
    endtask

    task automatic test_midframe();
        bit seen = 1'b0;
        logic [7:0] es;
        wait_which(3'd3);
        pulse_load(32'hFFFF0000);
        for (int i = 0; i < 40 && !seen; i++) begin
            n_checks++; if (seg !== tab_1234[which]) begin n_fail++; $display("FAIL midframe_old[%0d]: got %h required %h", which, seg, tab_1234[which]); end
            @(negedge clk);
            seen = frame_done;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL midframe_frame_done: not seen, required 1"); end
        for (int i = 0; i < 32; i++) begin
            es = (i / 4 < 4) ? 8'h3F : 8'h71;
            n_checks++; if (seg !== es) begin n_fail++; $display("FAIL midframe_new[%0d]: got %h required %h", i, seg, es); end
            @(negedge clk);
        end
    endtask

    task automatic test_bypass();
        wait_frame();
        repeat (31) @(negedge clk);
        n_checks++; if (which !== 3'd7) begin n_fail++; $display("FAIL bypass_align: got %0d required 7", which); end
        pulse_load(32'h00000009);
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL bypass_frame_done: got %b required 1", frame_done); end
        n_checks++; if (which !== 3'd0) begin n_fail++; $display("FAIL bypass_which: got %0d required 0", which); end
        n_checks++; if (seg !== 8'h6F) begin n_fail++; $display("FAIL bypass_seg: got %h required 6f", seg); end
        wait_which(3'd1);
        n_checks++; if (seg !== LZ) begin n_fail++; $display("FAIL bypass_digit1: got %h required %h", seg, LZ); end
        wait_frame();
        n_checks++; if (seg !== 8'h6F) begin n_fail++; $display("FAIL bypass_pending: got %h required 6f", seg); end
    endtask

    task automatic test_multi_load();
        wait_which(3'd2);
        pulse_load(32'h11111111);
        pulse_load(32'h22222222);
        n_checks++; if (seg !== LZ) begin n_fail++; $display("FAIL multi_old_frame: got %h required %h", seg, LZ); end
        wait_frame();
        for (int i = 0; i < 32; i++) begin
            n_checks++; if (seg !== 8'h5B) begin n_fail++; $display("FAIL multi_last_wins[%0d]: got %h required 5b", i, seg); end
            @(negedge clk);
        end
    endtask

    task automatic test_dp();
        logic [7:0] es;
        pulse_load(32'h0);
        wait_frame();
        dp_mask = 8'h04;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            if (which == 3'd2)      es = LZ | 8'h80;
            else if (which == 3'd0) es = 8'h3F;
            else                    es = LZ;
            n_checks++; if (seg !== es) begin n_fail++; $display("FAIL dp_seg[%0d]: got %h required %h", which, seg, es); end
            n_checks++; if (seg_n !== ~es) begin n_fail++; $display("FAIL dp_seg_act_low[%0d]: got %h required %h", which, seg_n, ~es); end
            @(negedge clk);
        end
        dp_mask = 8'h00;
    endtask

    task automatic test_blank();
        logic [7:0] es;
        pulse_load(32'h000000A0);
        wait_frame();
        for (int i = 0; i < 32; i++) begin
            case (i / 4)
                0:       es = 8'h3F;
                1:       es = 8'h77;
                default: es = LZ;
            endcase
            n_checks++; if (seg !== es) begin n_fail++; $display("FAIL blank_seg[%0d]: got %h required %h", i, seg, es); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_midframe();
        test_bypass();
        test_multi_load();
        test_dp();
        test_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
